// File: rtl/axil_timer_slave_if.sv
// AXI4-Lite bus bundle between an AXI master and the timer register front end.
// slave modport is the register-block side; master modport is the initiator.
interface axil_timer_slave_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_timer_slave.sv
// AXI4-Lite slave front end driving the timer register block's wr/rd strobes; AXIL_SLVERR_EN enables decode errors.
// Latency: AW+W (or AR) handshake at cycle 0 -> reg strobe at 1 -> B/R valid at 2.
// Backpressure: one transaction per channel in flight; AW/W/AR stall until the response is taken.
module axil_timer_slave #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst,
    axil_timer_slave_if.slave s,
    output logic [AW-1:0]  reg_wr_addr,
    output logic [DW-1:0]  reg_wr_data,
    output logic           reg_wr_en,
    input  logic           reg_wr_ready,
    output logic [AW-1:0]  reg_rd_addr,
    output logic           reg_rd_en,
    input  logic [DW-1:0]  reg_rd_data,
    input  logic           reg_rd_valid
);
    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} rstate_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [AW-1:0] ADDR_MAX    = AW'(12);
    localparam logic [AW-1:0] ADDR_COUNT  = AW'(8);

    function automatic logic addr_err(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (a > ADDR_MAX);
    endfunction

    logic [DW/8-1:0] wr_strb_q, wr_strb_d;
`else
    // Full-word writes only; strobes carry no information in this build.
    logic wstrb_unused;
    assign wstrb_unused = ^s.s_wstrb;
`endif

    wstate_e       wstate_q, wstate_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          aw_rdy, w_rdy, wr_en, bvld;

    rstate_e       rstate_q, rstate_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          ar_rdy, rd_en, rvld, rd_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= R_IDLE;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef AXIL_SLVERR_EN
            wr_strb_q <= '0;
`endif
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef AXIL_SLVERR_EN
            wr_strb_q <= wr_strb_d;
`endif
        end
    end

    // Write path: AW and W are latched independently; issue once both are held.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bresp_d   = bresp_q;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        wr_en     = 1'b0;
        bvld      = 1'b0;
`ifdef AXIL_SLVERR_EN
        wr_strb_d = wr_strb_q;
`endif
        case (wstate_q)
            W_IDLE: begin
                aw_rdy = !aw_held_q && !rst;
                w_rdy  = !w_held_q && !rst;
                if (s.s_awvalid && aw_rdy) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = s.s_awaddr;
                end
                if (s.s_wvalid && w_rdy) begin
                    w_held_d  = 1'b1;
                    wr_data_d = s.s_wdata;
`ifdef AXIL_SLVERR_EN
                    wr_strb_d = s.s_wstrb;
`endif
                end
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
`ifdef AXIL_SLVERR_EN
                    if (addr_err(wr_addr_d) || (wr_addr_d == ADDR_COUNT) || (wr_strb_d != '1)) begin
                        wstate_d = W_RESP;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        wstate_d = W_ISSUE;
                        bresp_d  = RESP_OKAY;
                    end
`else
                    wstate_d = W_ISSUE;
                    bresp_d  = RESP_OKAY;
`endif
                end
            end
            W_ISSUE: begin
                wr_en = !rst;
                if (reg_wr_ready) wstate_d = W_RESP;
            end
            W_RESP: begin
                bvld = !rst;
                if (s.s_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
`ifdef AXIL_SLVERR_EN
        rd_err = addr_err(s.s_araddr);
`else
        rd_err = 1'b0;
`endif
        rstate_d  = rstate_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_rdy    = 1'b0;
        rd_en     = 1'b0;
        rvld      = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                ar_rdy = !rst;
                if (s.s_arvalid && ar_rdy) begin
                    rd_addr_d = s.s_araddr;
                    if (rd_err) begin
                        rstate_d = R_RESP;
                        rdata_d  = '0;
`ifdef AXIL_SLVERR_EN
                        rresp_d  = RESP_SLVERR;
`else
                        rresp_d  = RESP_OKAY;
`endif
                    end else begin
                        rstate_d = R_ISSUE;
                    end
                end
            end
            R_ISSUE: begin
                rd_en = !rst;
                if (reg_rd_valid) begin
                    rdata_d  = reg_rd_data;
                    rresp_d  = RESP_OKAY;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                rvld = !rst;
                if (s.s_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign s.s_awready = aw_rdy;
    assign s.s_wready  = w_rdy;
    assign s.s_bvalid  = bvld;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = ar_rdy;
    assign s.s_rvalid  = rvld;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;

    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_wr_en   = wr_en;
    assign reg_rd_addr = rd_addr_q;
    assign reg_rd_en   = rd_en;
endmodule

// File: tb/tb_axil_timer_slave.sv
// Directed bench for axil_timer_slave: vector table of single transactions plus
// hand sequences for latency, W-before-AW, R backpressure, wr stall and reset abort.
module tb_axil_timer_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  reg_wr_addr, reg_rd_addr;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic        reg_wr_en, reg_rd_en, reg_wr_ready, reg_rd_valid;
    logic        wr_ready_drv = 1'b1;
    logic        rd_valid_gate = 1'b1;
    logic [31:0] rd_data_drv = '0;

    int checks = 0;
    int errors = 0;
    int wr_en_cycles = 0, wr_acc = 0, rd_acc = 0, b_beats = 0, r_beats = 0, rvalid_cycles = 0;
    logic [3:0]  last_wr_addr = '0, last_rd_addr = '0;
    logic [31:0] last_wr_data = '0;

    axil_timer_slave_if #(.AW(4), .DW(32)) bif ();

    axil_timer_slave #(.AW(4), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (bif),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_ready (reg_wr_ready),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid)
    );

    always #5 clk = ~clk;

    assign reg_wr_ready = wr_ready_drv;
    assign reg_rd_valid = reg_rd_en & rd_valid_gate;
    assign reg_rd_data  = rd_data_drv;

    always @(posedge clk) begin
        if (reg_wr_en) wr_en_cycles <= wr_en_cycles + 1;
        if (reg_wr_en && reg_wr_ready) begin
            wr_acc       <= wr_acc + 1;
            last_wr_addr <= reg_wr_addr;
            last_wr_data <= reg_wr_data;
        end
        if (reg_rd_en && reg_rd_valid) begin
            rd_acc       <= rd_acc + 1;
            last_rd_addr <= reg_rd_addr;
        end
        if (bif.s_bvalid && bif.s_bready) b_beats <= b_beats + 1;
        if (bif.s_rvalid && bif.s_rready) r_beats <= r_beats + 1;
        if (bif.s_rvalid) rvalid_cycles <= rvalid_cycles + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        bit          exp_en;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(bit w, logic [3:0] a, logic [31:0] d, logic [3:0] st,
                                logic [1:0] rsp, bit en, logic [31:0] rd);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = st;
        v.exp_resp = rsp; v.exp_en = en; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                            output logic [1:0] resp, output bit ok);
        bit aw_hs, w_hs, b_hs;
        bif.s_awaddr = a; bif.s_awvalid = 1'b1;
        bif.s_wdata = d; bif.s_wstrb = st; bif.s_wvalid = 1'b1;
        bif.s_bready = 1'b1;
        ok = 1'b0;
        resp = 2'bxx;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            aw_hs = bif.s_awvalid && bif.s_awready;
            w_hs  = bif.s_wvalid && bif.s_wready;
            b_hs  = bif.s_bvalid && bif.s_bready;
            if (b_hs) resp = bif.s_bresp;
            @(posedge clk); #1;
            if (aw_hs) bif.s_awvalid = 1'b0;
            if (w_hs) bif.s_wvalid = 1'b0;
            if (b_hs) begin ok = 1'b1; break; end
        end
        bif.s_awvalid = 1'b0; bif.s_wvalid = 1'b0; bif.s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output logic [31:0] rd, output bit ok);
        bit ar_hs, r_hs;
        bif.s_araddr = a; bif.s_arvalid = 1'b1; bif.s_rready = 1'b1;
        rd_data_drv = d;
        ok = 1'b0;
        resp = 2'bxx; rd = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ar_hs = bif.s_arvalid && bif.s_arready;
            r_hs  = bif.s_rvalid && bif.s_rready;
            if (r_hs) begin resp = bif.s_rresp; rd = bif.s_rdata; end
            @(posedge clk); #1;
            if (ar_hs) bif.s_arvalid = 1'b0;
            if (r_hs) begin ok = 1'b1; break; end
        end
        bif.s_arvalid = 1'b0; bif.s_rready = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int b0, a0, e0, r0, rv0;
        logic [1:0]  resp;
        logic [31:0] rd;
        bit ok;

        vecs[0] = mk(1, 4'h0, 32'hDEAD_BEEF, 4'hF, 2'b00, 1, 32'h0);
        vecs[1] = mk(1, 4'h4, 32'h0000_1234, 4'hF, 2'b00, 1, 32'h0);
        vecs[2] = mk(1, 4'hC, 32'hA5A5_0001, 4'hF, 2'b00, 1, 32'h0);
        vecs[3] = mk(0, 4'h0, 32'h0000_CAFE, 4'hF, 2'b00, 1, 32'h0000_CAFE);
        vecs[4] = mk(0, 4'hC, 32'h0F0F_0F0F, 4'hF, 2'b00, 1, 32'h0F0F_0F0F);
        vecs[5] = mk(0, 4'h8, 32'h0000_0077, 4'hF, 2'b00, 1, 32'h0000_0077);
`ifdef AXIL_SLVERR_EN
        vecs[6] = mk(1, 4'h8, 32'h0000_0007, 4'hF, 2'b10, 0, 32'h0);
        vecs[7] = mk(1, 4'h4, 32'h0000_00AB, 4'h3, 2'b10, 0, 32'h0);
        vecs[8] = mk(0, 4'h6, 32'h0000_0099, 4'hF, 2'b10, 0, 32'h0);
        vecs[9] = mk(1, 4'h2, 32'h0000_0011, 4'hF, 2'b10, 0, 32'h0);
`else
        vecs[6] = mk(1, 4'h8, 32'h0000_0007, 4'hF, 2'b00, 1, 32'h0);
        vecs[7] = mk(1, 4'h4, 32'h0000_00AB, 4'h3, 2'b00, 1, 32'h0);
        vecs[8] = mk(0, 4'h6, 32'h0000_0099, 4'hF, 2'b00, 1, 32'h0000_0099);
        vecs[9] = mk(1, 4'h2, 32'h0000_0011, 4'hF, 2'b00, 1, 32'h0);
`endif

        bif.s_awaddr = '0; bif.s_awvalid = 1'b0; bif.s_wdata = '0; bif.s_wstrb = '0;
        bif.s_wvalid = 1'b0; bif.s_bready = 1'b0; bif.s_araddr = '0; bif.s_arvalid = 1'b0;
        bif.s_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset release
        @(negedge clk);
        check("rst_awready", bif.s_awready, 1);
        check("rst_wready", bif.s_wready, 1);
        check("rst_arready", bif.s_arready, 1);
        check("rst_bvalid", bif.s_bvalid, 0);
        check("rst_rvalid", bif.s_rvalid, 0);
        check("rst_strobes", {reg_wr_en, reg_rd_en}, 0);

        // AW+W same cycle: strobe at +1, B at +2
        @(posedge clk); #1;
        bif.s_awaddr = 4'h4; bif.s_awvalid = 1'b1;
        bif.s_wdata = 32'h0000_1234; bif.s_wstrb = 4'hF; bif.s_wvalid = 1'b1;
        bif.s_bready = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0; bif.s_wvalid = 1'b0;
        @(negedge clk);
        check("lat_wr_en", reg_wr_en, 1);
        check("lat_wr_addr", reg_wr_addr, 4'h4);
        check("lat_wr_data", reg_wr_data, 32'h0000_1234);
        check("lat_bvalid_early", bif.s_bvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_bvalid", {bif.s_bvalid, bif.s_bresp}, 3'b100);
        check("lat_wr_en_off", reg_wr_en, 0);
        check("lat_no_aw_in_resp", bif.s_awready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_idle", {bif.s_bvalid, bif.s_awready}, 2'b01);
        @(posedge clk); #1;
        bif.s_bready = 1'b0;

        // Vector table
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                a0 = wr_acc;
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
                check($sformatf("v%0d_wr_done", i), ok, 1);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("v%0d_wr_cnt", i), wr_acc - a0, vecs[i].exp_en);
                if (vecs[i].exp_en) begin
                    check($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
                    check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].data);
                end
            end else begin
                a0 = rd_acc;
                do_read(vecs[i].addr, vecs[i].data, resp, rd, ok);
                check($sformatf("v%0d_rd_done", i), ok, 1);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("v%0d_rd_cnt", i), rd_acc - a0, vecs[i].exp_en);
                if (vecs[i].exp_en)
                    check($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].addr);
            end
        end

        // W three cycles ahead of AW
        b0 = b_beats; a0 = wr_acc;
        bif.s_wdata = 32'h0000_0077; bif.s_wstrb = 4'hF; bif.s_wvalid = 1'b1;
        bif.s_bready = 1'b1;
        @(posedge clk); #1;
        bif.s_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("wfirst_wready", bif.s_wready, 0);
        check("wfirst_awready", bif.s_awready, 1);
        check("wfirst_no_issue", wr_acc - a0, 0);
        @(posedge clk); #1;
        bif.s_awaddr = 4'hC; bif.s_awvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("wfirst_wr_cnt", wr_acc - a0, 1);
        check("wfirst_b_cnt", b_beats - b0, 1);
        check("wfirst_data", {last_wr_addr, last_wr_data}, {4'hC, 32'h0000_0077});
        bif.s_bready = 1'b0;

        // Read with rready held low for 4 cycles
        r0 = r_beats;
        rd_data_drv = 32'h55;
        bif.s_araddr = 4'h8; bif.s_arvalid = 1'b1; bif.s_rready = 1'b0;
        @(posedge clk); #1;
        bif.s_arvalid = 1'b0;
        @(posedge clk); #1;
        rd_data_drv = 32'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rhold_%0d", i), {bif.s_rvalid, bif.s_rresp, bif.s_rdata}, {1'b1, 2'b00, 32'h55});
            @(posedge clk); #1;
        end
        bif.s_rready = 1'b1;
        @(posedge clk); #1;
        bif.s_rready = 1'b0;
        @(negedge clk);
        check("rhold_beats", r_beats - r0, 1);
        check("rhold_done", bif.s_rvalid, 0);

        // reg_wr_ready low for 5 cycles
        e0 = wr_en_cycles; b0 = b_beats;
        wr_ready_drv = 1'b0;
        @(posedge clk); #1;
        bif.s_awaddr = 4'h0; bif.s_awvalid = 1'b1;
        bif.s_wdata = 32'h0000_0005; bif.s_wstrb = 4'hF; bif.s_wvalid = 1'b1;
        bif.s_bready = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0; bif.s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_en_%0d", i), {reg_wr_en, bif.s_bvalid}, 2'b10);
            @(posedge clk); #1;
        end
        wr_ready_drv = 1'b1;
        @(negedge clk);
        check("stall_last_en", {reg_wr_en, bif.s_bvalid}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_bvalid", {reg_wr_en, bif.s_bvalid}, 2'b01);
        @(posedge clk); #1;
        bif.s_bready = 1'b0;
        check("stall_en_cycles", wr_en_cycles - e0, 6);
        check("stall_b_cnt", b_beats - b0, 1);

        // Reset while the read is waiting in issue
        rd_valid_gate = 1'b0;
        bif.s_araddr = 4'h4; bif.s_arvalid = 1'b1; bif.s_rready = 1'b1;
        @(posedge clk); #1;
        bif.s_arvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_rd_en", reg_rd_en, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_valid_gate = 1'b1;
        rv0 = rvalid_cycles; r0 = r_beats;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_rvalid", rvalid_cycles - rv0, 0);
        check("abort_no_rbeat", r_beats - r0, 0);
        @(negedge clk);
        check("abort_idle", {reg_rd_en, bif.s_arready}, 2'b01);
        bif.s_rready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
